regfile_port_arbiter: RTL and testbench

//  Shares the decode-stage register file between the pipeline (ID reads rs/rt, WB writes) and the debug unit.

---
 rtl/regfile_port_arbiter.sv | 138 +++++++++++++
 tb/tb_regfile_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Shares the decode-stage register file between the ID/WB pipeline and the debug unit.
// Optional build macro RFARB_WB_BYPASS_EN: debug reads forward same-cycle WB data to the same register.
module regfile_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int WR_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [ADDR_W-1:0] i_id_rs,
  input  logic [ADDR_W-1:0] i_id_rt,
  input  logic [DATA_W-1:0] i_rf_rd_data1,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_wr_addr,
  output logic [DATA_W-1:0] o_rf_wr_data,
  output logic [ADDR_W-1:0] o_rf_rd_addr1,
  output logic [ADDR_W-1:0] o_rf_rd_addr2,
  input  logic              i_dbg_req_valid,
  output logic              o_dbg_req_ready,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_resp_valid,
  input  logic              i_dbg_resp_ready,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_stall_req,
  output logic              o_busy
);

  // Handshakes: a request transfers on a rising edge where i_dbg_req_valid && o_dbg_req_ready;
  // a response transfers on a rising edge where o_dbg_resp_valid && i_dbg_resp_ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(WR_TIMEOUT);

  state_t            state;
  state_t            state_next;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_cnt_next;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rdata_next;
  logic [DATA_W-1:0] rd_value;
  logic              req_fire;
  logic              timed_out;

  assign req_fire  = (state == IDLE) && i_dbg_req_valid;
  assign timed_out = (wait_cnt >= TIMEOUT);

  always_comb begin
    rd_value = i_rf_rd_data1;
`ifdef RFARB_WB_BYPASS_EN
    if (i_wb_we && (i_wb_addr == lat_addr)) rd_value = i_wb_data;
`endif
    // Register 0 reads as zero whatever the file holds there.
    if (lat_addr == '0) rd_value = '0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rdata     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      rdata    <= rdata_next;
      if (req_fire) begin
        lat_addr  <= i_dbg_addr;
        lat_wdata <= i_dbg_wdata;
      end
    end
  end

  always_comb begin
    state_next       = state;
    wait_cnt_next    = wait_cnt;
    rdata_next       = rdata;
    o_dbg_req_ready  = 1'b0;
    o_dbg_resp_valid = 1'b0;
    o_stall_req      = 1'b0;
    o_rf_rd_addr1    = i_id_rs;
    o_rf_we          = i_wb_we;
    o_rf_wr_addr     = i_wb_addr;
    o_rf_wr_data     = i_wb_data;
    case (state)
      IDLE: begin
        o_dbg_req_ready = 1'b1;
        if (i_dbg_req_valid) begin
          state_next = i_dbg_we ? WR : RD;
          rdata_next = '0;
        end
      end
      RD: begin
        o_stall_req   = 1'b1;
        o_rf_rd_addr1 = lat_addr;
        rdata_next    = rd_value;
        state_next    = RESP;
      end
      WR: begin
        o_stall_req = timed_out;
        if (!i_wb_we) begin
          // Free WB slot: take the write port; writes to register 0 are dropped.
          if ((lat_addr != '0) && !i_rst) begin
            o_rf_we      = 1'b1;
            o_rf_wr_addr = lat_addr;
            o_rf_wr_data = lat_wdata;
          end
          wait_cnt_next = '0;
          state_next    = RESP;
        end else if (!timed_out) begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      RESP: begin
        o_dbg_resp_valid = 1'b1;
        if (i_dbg_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rf_rd_addr2 = i_id_rt;
  assign o_dbg_rdata   = rdata;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_regfile_port_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int WR_TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [DATA_W-1:0] rf_rd_data1;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic [ADDR_W-1:0] rf_rd_addr1;
  logic [ADDR_W-1:0] rf_rd_addr2;
  logic              dbg_req_valid;
  logic              dbg_req_ready;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_resp_valid;
  logic              dbg_resp_ready;
  logic [DATA_W-1:0] dbg_rdata;
  logic              stall_req;
  logic              busy;

  regfile_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_TIMEOUT(WR_TIMEOUT)) dut (
    .clk(clk), .i_rst(rst),
    .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_rf_rd_data1(rf_rd_data1),
    .o_rf_we(rf_we), .o_rf_wr_addr(rf_wr_addr), .o_rf_wr_data(rf_wr_data),
    .o_rf_rd_addr1(rf_rd_addr1), .o_rf_rd_addr2(rf_rd_addr2),
    .i_dbg_req_valid(dbg_req_valid), .o_dbg_req_ready(dbg_req_ready),
    .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_resp_valid(dbg_resp_valid), .i_dbg_resp_ready(dbg_resp_ready),
    .o_dbg_rdata(dbg_rdata), .o_stall_req(stall_req), .o_busy(busy)
  );

  // Clock / environment register file (combinational read port 1)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] env_rf [32];
  assign rf_rd_data1 = env_rf[rf_rd_addr1];
  always @(posedge clk) if (rf_we) env_rf[rf_wr_addr] <= rf_wr_data;

  // Reference model and scoreboard
  logic [DATA_W-1:0] model_rf [32];
  logic [DATA_W-1:0] exp_q [$];
  bit                model_ok;
  bit                txn_active;
  bit                txn_done;
  bit                txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  int                busy_cycles;
  int                n_cmp;
  int                n_err;

  // Observations used by directed scenarios
  int                cyc;
  int                hs_cyc;
  int                stall_cnt;
  int                first_stall;
  int                last_stall;
  int                write_cyc;
  int                resp_cyc;
  int                dbg_wr_cnt;
  logic [DATA_W-1:0] last_resp;
  logic [DATA_W-1:0] wr_data_seen;
  logic [ADDR_W-1:0] wr_addr_seen;
  logic [ADDR_W-1:0] rs_drv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input bit rr, input bit wwe,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    bit                e_ready, e_busy, e_stall, e_resp, e_we;
    logic [ADDR_W-1:0] e_rd1, e_wa;
    logic [DATA_W-1:0] e_wd, rv;
    bit                hs, finish_op, resp_hs;
    rst = r; dbg_req_valid = v; dbg_we = w; dbg_addr = a; dbg_wdata = d;
    dbg_resp_ready = rr; wb_we = wwe; wb_addr = wa; wb_data = wd;
    id_rs = rs_drv; id_rt = 5'($urandom_range(0, 31));
    #3;
    e_ready = !txn_active; e_busy = txn_active; e_stall = 1'b0; e_resp = 1'b0;
    e_rd1 = rs_drv; e_we = wwe; e_wa = wa; e_wd = wd; rv = '0;
    hs = !txn_active && v; finish_op = 1'b0; resp_hs = 1'b0;
    if (txn_active && !txn_done) begin
      if (!txn_we) begin
        e_stall = 1'b1; e_rd1 = txn_addr; finish_op = 1'b1;
        if (txn_addr == '0) rv = '0;
`ifdef RFARB_WB_BYPASS_EN
        else if (wwe && wa == txn_addr) rv = wd;
`endif
        else rv = model_rf[txn_addr];
      end else begin
        e_stall = (busy_cycles >= WR_TIMEOUT);
        if (!wwe) begin
          finish_op = 1'b1;
          if (txn_addr != '0 && !r) begin
            e_we = 1'b1; e_wa = txn_addr; e_wd = txn_wdata;
          end
        end
      end
    end else if (txn_active) begin
      e_resp = 1'b1; resp_hs = rr;
    end
    if (model_ok) begin
      check("req_ready", 32'(dbg_req_ready), 32'(e_ready));
      check("busy", 32'(busy), 32'(e_busy));
      check("stall_req", 32'(stall_req), 32'(e_stall));
      check("resp_valid", 32'(dbg_resp_valid), 32'(e_resp));
      check("rf_rd_addr1", 32'(rf_rd_addr1), 32'(e_rd1));
      check("rf_rd_addr2", 32'(rf_rd_addr2), 32'(id_rt));
      check("rf_we", 32'(rf_we), 32'(e_we));
      check("rf_wr_addr", 32'(rf_wr_addr), 32'(e_wa));
      check("rf_wr_data", rf_wr_data, e_wd);
      if (e_resp) begin
        if (exp_q.size() > 0) check("dbg_rdata", dbg_rdata, exp_q[0]);
        else check("resp_queue_empty", 32'(exp_q.size()), 32'd1);
      end
      if (dbg_req_ready && v) begin
        hs_cyc = cyc; stall_cnt = 0; first_stall = -1; last_stall = -1;
        write_cyc = -1; resp_cyc = -1;
      end
      if (stall_req) begin
        stall_cnt++;
        if (first_stall < 0) first_stall = cyc;
        last_stall = cyc;
      end
      if (rf_we && !wwe) begin
        write_cyc = cyc; dbg_wr_cnt++; wr_addr_seen = rf_wr_addr; wr_data_seen = rf_wr_data;
      end
      if (dbg_resp_valid && resp_cyc < 0) resp_cyc = cyc;
      if (dbg_resp_valid && rr) last_resp = dbg_rdata;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (wwe) model_rf[wa] = wd;
    if (r) begin
      txn_active = 1'b0; txn_done = 1'b0; exp_q.delete(); model_ok = 1'b1;
    end else begin
      if (finish_op) begin
        if (txn_we && txn_addr != '0) model_rf[txn_addr] = txn_wdata;
        exp_q.push_back(rv);
        txn_done = 1'b1;
      end else if (txn_active && txn_we && !txn_done && wwe) begin
        busy_cycles++;
      end
      if (resp_hs) begin
        void'(exp_q.pop_front());
        txn_active = 1'b0;
      end
      if (hs) begin
        txn_active = 1'b1; txn_done = 1'b0; txn_we = w;
        txn_addr = a; txn_wdata = d; busy_cycles = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    int                base_wr;
    bit                heavy;
    logic [ADDR_W-1:0] ra, rwa;
    logic [DATA_W-1:0] rd, rwd;
    n_cmp = 0; n_err = 0; cyc = 0; model_ok = 1'b0;
    txn_active = 1'b0; txn_done = 1'b0; txn_we = 1'b0; txn_addr = '0; txn_wdata = '0;
    busy_cycles = 0; hs_cyc = 0; stall_cnt = 0; first_stall = -1; last_stall = -1;
    write_cyc = -1; resp_cyc = -1; dbg_wr_cnt = 0; last_resp = '0;
    wr_data_seen = '0; wr_addr_seen = '0; rs_drv = 5'd7;

    // Reset, then idle with i_id_rs = 7
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_resp_valid", 32'(dbg_resp_valid), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    idle(1);
    check("idle_rd_addr1", 32'(rf_rd_addr1), 32'd7);
    check("idle_req_ready", 32'(dbg_req_ready), 32'd1);

    // Populate every register through the WB path
    for (int i = 0; i < 32; i++) begin
      rd = (i == 5) ? 32'hDEADBEEF : (i == 9) ? 32'h1 : $urandom();
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'(i), rd);
    end

    // Debug read of register 5
    step(1'b0, 1'b1, 1'b0, 5'd5, '0, 1'b1, 1'b0, '0, '0);
    idle(3);
    check("rd_stall_cycles", 32'(stall_cnt), 32'd1);
    check("rd_stall_at", 32'(first_stall - hs_cyc), 32'd1);
    check("rd_resp_at", 32'(resp_cyc - hs_cyc), 32'd2);
    check("rd_data", last_resp, 32'hDEADBEEF);

    // Debug write of register 3, no WB contention
    step(1'b0, 1'b1, 1'b1, 5'd3, 32'h12345678, 1'b1, 1'b0, '0, '0);
    idle(3);
    check("wr_at", 32'(write_cyc - hs_cyc), 32'd1);
    check("wr_addr", 32'(wr_addr_seen), 32'd3);
    check("wr_data", wr_data_seen, 32'h12345678);
    check("wr_resp_at", 32'(resp_cyc - hs_cyc), 32'd2);
    check("wr_rdata", last_resp, 32'd0);

    // Debug write starved by continuous WB traffic
    step(1'b0, 1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 1'b1, 5'd10, 32'h10);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'd10, 32'(i));
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    idle(3);
    check("to_stall_at", 32'(first_stall - hs_cyc), 32'(WR_TIMEOUT + 1));
    check("to_write_at", 32'(write_cyc - hs_cyc), 32'd21);
    check("to_stall_end", 32'(last_stall - hs_cyc), 32'd21);
    check("to_wr_data", wr_data_seen, 32'hCAFEF00D);

    // Debug read of register 9 while WB rewrites it during the read cycle
    step(1'b0, 1'b1, 1'b0, 5'd9, '0, 1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'd9, 32'hA5A5A5A5);
    idle(3);
`ifdef RFARB_WB_BYPASS_EN
    check("bypass_rdata", last_resp, 32'hA5A5A5A5);
`else
    check("bypass_rdata", last_resp, 32'h1);
`endif

    // Write to register 0: no register file write, response still returned
    base_wr = dbg_wr_cnt;
    step(1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, '0, '0);
    idle(3);
    check("zero_wr_count", 32'(dbg_wr_cnt - base_wr), 32'd0);
    check("zero_resp_at", 32'(resp_cyc - hs_cyc), 32'd2);

    // Reset while a response is held back
    step(1'b0, 1'b1, 1'b0, 5'd5, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    check("hold_resp_valid", 32'(dbg_resp_valid), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    check("rst_resp_drop", 32'(dbg_resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata2", dbg_rdata, 32'd0);
    idle(2);

    // Random traffic against the model
    heavy = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) heavy = 1'($urandom_range(0, 1));
      rs_drv = 5'($urandom_range(0, 31));
      ra = 5'($urandom_range(0, 31));
      rwa = 5'($urandom_range(0, 31));
      rd = $urandom();
      rwd = $urandom();
      step($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           ra, rd, $urandom_range(0, 3) != 0,
           heavy ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1)), rwa, rwd);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
